// File: rtl/regfile_dumper.sv
// regfile_dumper: streams the 32 registers of one selected core lane out of a
// two-read-port register file as a valid/ready beat sequence (address, data),
// two registers per fetch.
//
// Optional feature: define REGDUMP_SKIP_ZERO_EN to omit the register 0 beat
// (31 beats, addresses 1..31). Without it all 32 registers are emitted.
//
// Handshake: a beat transfers on a rising edge where dump_valid && dump_ready.
// Once dump_valid rises it stays high, with dump_address/dump_data held stable,
// until that transfer happens.
module regfile_dumper #(
  parameter int cores = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             core_select,
  output logic [cores-1:0][4:0]  read_address_1,
  output logic [cores-1:0][4:0]  read_address_2,
  input  logic [cores-1:0][31:0] read_data_1,
  input  logic [cores-1:0][31:0] read_data_2,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [4:0]             dump_address,
  output logic [31:0]            dump_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef logic [cores-1:0][4:0] addrVec_t;

`ifdef REGDUMP_SKIP_ZERO_EN
  localparam bit skipZero = 1'b1;
`else
  localparam bit skipZero = 1'b0;
`endif

  // Compared against a zero-extended core_select so cores=16 still fits.
  localparam logic [4:0] laneCount = 5'(cores);

  state_t      state;
  logic [3:0]  lane;
  logic [3:0]  pair;
  logic [31:0] bufferA;
  logic [31:0] bufferB;
  logic        sendingB;
  logic [31:0] laneData1;
  logic [31:0] laneData2;

  // Drive a read address on the chosen lane only; every other lane reads 0.
  function automatic addrVec_t laneAddr(input logic [3:0] sel, input logic [4:0] addr);
    laneAddr = '0;
    for (int i = 0; i < cores; i++) begin
      if (sel == 4'(i)) laneAddr[i] = addr;
    end
  endfunction

  // Select the latched lane's read data without a variable-width index.
  always_comb begin
    laneData1 = '0;
    laneData2 = '0;
    for (int i = 0; i < cores; i++) begin
      if (lane == 4'(i)) begin
        laneData1 = read_data_1[i];
        laneData2 = read_data_2[i];
      end
    end
  end

  // Beat data comes straight from the captured buffers; zero when no beat.
  always_comb begin
    dump_data = '0;
    if (dump_valid) dump_data = sendingB ? bufferB : bufferA;
  end

  // Dump sequencer: fetch a register pair, send it as two beats, repeat for 16 pairs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lane           <= '0;
      pair           <= '0;
      bufferA        <= '0;
      bufferB        <= '0;
      sendingB       <= 1'b0;
      read_address_1 <= '0;
      read_address_2 <= '0;
      dump_valid     <= 1'b0;
      dump_address   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ({1'b0, core_select} < laneCount) begin
              lane           <= core_select;
              pair           <= '0;
              busy           <= 1'b1;
              read_address_1 <= laneAddr(core_select, 5'd0);
              read_address_2 <= laneAddr(core_select, 5'd1);
              state          <= FETCH;
            end else begin
              error <= 1'b1;
            end
          end
        end
        FETCH: begin
          bufferA        <= laneData1;
          bufferB        <= laneData2;
          read_address_1 <= '0;
          read_address_2 <= '0;
          dump_valid     <= 1'b1;
          if (skipZero && pair == 4'd0) begin
            dump_address <= 5'd1;
            sendingB     <= 1'b1;
            state        <= SEND_B;
          end else begin
            dump_address <= {pair, 1'b0};
            sendingB     <= 1'b0;
            state        <= SEND_A;
          end
        end
        SEND_A: begin
          if (dump_ready) begin
            dump_address <= {pair, 1'b1};
            sendingB     <= 1'b1;
            state        <= SEND_B;
          end
        end
        SEND_B: begin
          if (dump_ready) begin
            dump_valid   <= 1'b0;
            dump_address <= '0;
            sendingB     <= 1'b0;
            if (pair == 4'd15) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pair           <= pair + 4'd1;
              read_address_1 <= laneAddr(lane, {pair + 4'd1, 1'b0});
              read_address_2 <= laneAddr(lane, {pair + 4'd1, 1'b1});
              state          <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper with four core lanes and a behavioural register file.
module tb_regfile_dumper;

  localparam int CORES = 4;
`ifdef REGDUMP_SKIP_ZERO_EN
  localparam int FIRST_ADDR  = 1;
  localparam int FULL_CYCLES = 47;
`else
  localparam int FIRST_ADDR  = 0;
  localparam int FULL_CYCLES = 48;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [3:0]             core_select;
  logic [CORES-1:0][4:0]  read_address_1;
  logic [CORES-1:0][4:0]  read_address_2;
  logic [CORES-1:0][31:0] read_data_1;
  logic [CORES-1:0][31:0] read_data_2;
  logic                   dump_valid;
  logic                   dump_ready;
  logic [4:0]             dump_address;
  logic [31:0]            dump_data;
  logic                   busy;
  logic                   done;
  logic                   error;

  logic [31:0] regs [CORES][32];
  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];
  int checks = 0;
  int failures = 0;
  int stable_err, drop_err, lane_err, busy_err, error_seen, post_busy;

  regfile_dumper #(.cores(CORES)) dut (
    .clk(clk), .reset(reset), .start(start), .core_select(core_select),
    .read_address_1(read_address_1), .read_address_2(read_address_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_address(dump_address), .dump_data(dump_data),
    .busy(busy), .done(done), .error(error)
  );

  // Clock
  always #5 clk = ~clk;

  // Combinational two-port register file per lane
  for (genvar g = 0; g < CORES; g++) begin : g_rf
    assign read_data_1[g] = regs[g][read_address_1[g]];
    assign read_data_2[g] = regs[g][read_address_2[g]];
  end

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; dump_ready = 1'b0; core_select = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_random();
    for (int l = 0; l < CORES; l++)
      for (int a = 0; a < 32; a++) regs[l][a] = $urandom;
  endtask

  // Reference: one beat per register from the first emitted address up to 31.
  task automatic build_exp(input int lane);
    exp_q.delete();
    for (int a = FIRST_ADDR; a < 32; a++) exp_q.push_back({5'(a), regs[lane][a]});
  endtask

  // Run one dump and record what was observed. mode: 0 ready always, 1 ready
  // one cycle in three, 2 random ready. noise issues random starts while busy.
  task automatic run_dump(input int lane_sel, input int mode, input bit noise,
                          input bit start_in_done, output int done_at);
    logic prev_stall;
    logic [4:0] prev_addr;
    logic [31:0] prev_data;
    got_q.delete();
    stable_err = 0; drop_err = 0; lane_err = 0; busy_err = 0; error_seen = 0;
    done_at = -1; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; core_select = 4'(lane_sel); dump_ready = 1'b0;
    for (int cyc = 1; cyc <= 600 && done_at < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (noise && $urandom_range(0, 3) == 0) begin
        start = 1'b1; core_select = 4'($urandom_range(0, 15));
      end
      case (mode)
        0: dump_ready = 1'b1;
        1: dump_ready = (cyc % 3 == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        if (dump_valid !== 1'b1) drop_err++;
        else if (dump_address !== prev_addr || dump_data !== prev_data) stable_err++;
      end
      if (dump_valid === 1'b1 && dump_ready) got_q.push_back({dump_address, dump_data});
      prev_stall = (dump_valid === 1'b1) && !dump_ready;
      prev_addr = dump_address; prev_data = dump_data;
      for (int i = 0; i < CORES; i++)
        if (i != lane_sel && (read_address_1[i] !== 5'd0 || read_address_2[i] !== 5'd0)) lane_err++;
      if (busy !== 1'b1) busy_err++;
      if (error !== 1'b0) error_seen++;
      if (done === 1'b1) begin
        done_at = cyc;
        start = start_in_done; core_select = 4'(lane_sel);
      end
    end
    @(negedge clk);
    post_busy = int'(busy);
    start = 1'b0;
  endtask

  task automatic compare_beats(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL %s beat_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s beat%0d got addr=%0d data=%h exp addr=%0d data=%h", name, i,
                 got_q[i][36:32], got_q[i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; core_select = '0; dump_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dump_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dump_valid); end
    checks++; if (dump_address !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", dump_address); end
    checks++; if (dump_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", dump_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (read_address_1 !== '0 || read_address_2 !== '0) begin
      failures++; $display("FAIL reset_raddr got=%h/%h exp=0", read_address_1, read_address_2);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_priority_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full_dump();
    int done_at;
    apply_reset();
    fill_random();
    for (int k = 0; k < 32; k++) regs[0][k] = 32'(k * 32'h11);
    build_exp(0);
    run_dump(0, 0, 1'b0, 1'b0, done_at);
    compare_beats("full");
    checks++; if (done_at !== 1 + FULL_CYCLES) begin failures++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_at, 1 + FULL_CYCLES); end
    checks++; if (busy_err !== 0) begin failures++; $display("FAIL full_busy_low got=%0d exp=0", busy_err); end
    checks++; if (post_busy !== 0) begin failures++; $display("FAIL full_post_busy got=%0d exp=0", post_busy); end
  endtask

  task automatic test_lane_select();
    int done_at;
    bit found;
    apply_reset();
    fill_random();
    regs[2][15] = 32'h10101;
    build_exp(2);
    run_dump(2, 0, 1'b0, 1'b0, done_at);
    found = 1'b0;
    foreach (got_q[i]) if (got_q[i][36:32] == 5'd15 && got_q[i][31:0] == 32'h10101) found = 1'b1;
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL lane2_reg15 got=absent exp=10101"); end
    checks++; if (lane_err !== 0) begin failures++; $display("FAIL lane_isolation got=%0d exp=0", lane_err); end
    compare_beats("lane2");
  endtask

  task automatic test_stall();
    int done_at;
    int lane;
    apply_reset();
    fill_random();
    lane = $urandom_range(0, CORES - 1);
    build_exp(lane);
    run_dump(lane, 1, 1'b1, 1'b0, done_at);
    checks++; if (stable_err !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stable_err); end
    checks++; if (drop_err !== 0) begin failures++; $display("FAIL stall_valid_drop got=%0d exp=0", drop_err); end
    checks++; if (error_seen !== 0) begin failures++; $display("FAIL busy_start_error got=%0d exp=0", error_seen); end
    checks++; if (done_at <= 0) begin failures++; $display("FAIL stall_done got=%0d exp=positive", done_at); end
    compare_beats("stall");
  endtask

  task automatic test_random_ready();
    int done_at;
    int lane;
    apply_reset();
    fill_random();
    lane = $urandom_range(0, CORES - 1);
    build_exp(lane);
    run_dump(lane, 2, 1'b1, 1'b0, done_at);
    checks++; if (stable_err + drop_err !== 0) begin failures++; $display("FAIL rand_stable got=%0d exp=0", stable_err + drop_err); end
    checks++; if (lane_err !== 0) begin failures++; $display("FAIL rand_lane got=%0d exp=0", lane_err); end
    compare_beats("random_ready");
  endtask

  task automatic test_bad_select();
    logic [3:0] sel [2];
    int activity;
    apply_reset();
    sel[0] = 4'd4;
    sel[1] = 4'($urandom_range(5, 15));
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start = 1'b1; core_select = sel[t];
      @(negedge clk);
      start = 1'b0;
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL bad_sel%0d_error got=%b exp=1", sel[t], error); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_sel%0d_busy got=%b exp=0", sel[t], busy); end
      activity = 0;
      repeat (4) begin
        @(negedge clk);
        if (error !== 1'b0 || busy !== 1'b0 || dump_valid !== 1'b0) activity++;
      end
      checks++; if (activity !== 0) begin failures++; $display("FAIL bad_sel%0d_after got=%0d exp=0", sel[t], activity); end
    end
  endtask

  task automatic test_reset_mid();
    int done_at;
    int lane;
    int done_count;
    bit hit;
    apply_reset();
    fill_random();
    lane = $urandom_range(0, CORES - 1);
    @(negedge clk);
    start = 1'b1; core_select = 4'(lane); dump_ready = 1'b1;
    hit = 1'b0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (dump_valid === 1'b1 && dump_address === 5'd9) begin
        hit = 1'b1; reset = 1'b1;
      end
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL mid_reach_beat9 got=absent exp=present"); end
    @(negedge clk);
    reset = 1'b0;
    checks++; if (dump_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", dump_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    done_count = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) done_count++;
    end
    checks++; if (done_count !== 0) begin failures++; $display("FAIL mid_reset_done got=%0d exp=0", done_count); end
    lane = (lane + 1) % CORES;
    build_exp(lane);
    run_dump(lane, 0, 1'b0, 1'b0, done_at);
    compare_beats("after_reset");
    checks++; if (done_at !== 1 + FULL_CYCLES) begin failures++; $display("FAIL after_reset_done got=%0d exp=%0d", done_at, 1 + FULL_CYCLES); end
  endtask

  task automatic test_back_to_back();
    int done_at;
    int lane;
    apply_reset();
    fill_random();
    lane = $urandom_range(0, CORES - 1);
    build_exp(lane);
    run_dump(lane, 0, 1'b0, 1'b1, done_at);
    compare_beats("b2b_first");
    checks++; if (post_busy !== 0) begin failures++; $display("FAIL start_in_done got_busy=%0d exp=0", post_busy); end
    lane = $urandom_range(0, CORES - 1);
    build_exp(lane);
    run_dump(lane, 0, 1'b0, 1'b0, done_at);
    compare_beats("b2b_second");
    checks++; if (done_at !== 1 + FULL_CYCLES) begin failures++; $display("FAIL b2b_done got=%0d exp=%0d", done_at, 1 + FULL_CYCLES); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dump_ready = 1'b0; core_select = '0;
    for (int l = 0; l < CORES; l++)
      for (int a = 0; a < 32; a++) regs[l][a] = '0;
    test_reset();
    test_full_dump();
    test_lane_select();
    test_stall();
    test_random_ready();
    test_bad_select();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 SHALL have parameter: cores, default 1, number of core lanes on the registerfile read ports (legal 1..16).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  single-cycle request to dump one core's 32 registers.
REQ-005 SHALL have port: core_select  input  4  core lane to dump; sampled only when start is accepted.
REQ-006 SHALL have port: read_address_1  output  [cores-1:0][4:0]  registerfile port-1 read address per lane.
REQ-007 SHALL have port: read_address_2  output  [cores-1:0][4:0]  registerfile port-2 read address per lane.
REQ-008 SHALL have port: read_data_1  input  [cores-1:0][31:0]  registerfile port-1 combinational read data.
REQ-009 SHALL have port: read_data_2  input  [cores-1:0][31:0]  registerfile port-2 combinational read data.
REQ-010 SHALL have port: dump_valid  output  1  dump beat present.
REQ-011 SHALL have port: dump_ready  input  1  consumer accepts beat.
REQ-012 SHALL have port: dump_address  output  5  register number of current beat.
REQ-013 SHALL have port: dump_data  output  32  register contents of current beat.
REQ-014 SHALL have port: busy, done, error  output  1 each  dump in progress / one-cycle completion pulse / one-cycle bad-request pulse.

Function
REQ-015 SHALL implement states IDLE, FETCH, SEND_A, SEND_B, DONE; busy=1 in all states except IDLE.
REQ-016 IDLE: start=1 with core_select<cores SHALL latch lane, clear pair counter (4 bit) and enter FETCH next cycle.
REQ-017 IDLE: start=1 with core_select>=cores SHALL stay IDLE and pulse error for exactly the next cycle.
REQ-018 FETCH (one cycle): latched lane SHALL be driven read_address_1=2*pair, read_address_2=2*pair+1; both read_data values captured into buffers A/B at cycle end; next state SEND_A.
REQ-019 Non-selected lanes, and all lanes outside FETCH, SHALL drive read addresses 0.
REQ-020 SEND_A SHALL assert dump_valid with dump_address=2*pair, dump_data=buffer A; on dump_valid&&dump_ready go SEND_B.
REQ-021 SEND_B SHALL assert dump_valid with dump_address=2*pair+1, dump_data=buffer B; on handshake go DONE if pair=15, else pair+1 and FETCH.
REQ-022 While dump_valid=1 and dump_ready=0, dump_address and dump_data SHALL hold stable; dump_valid SHALL not drop before handshake.
REQ-023 dump_valid SHALL be 0 in IDLE, FETCH, DONE; beats SHALL issue in ascending address order 0..31.
REQ-024 Latency: start accepted at edge N -> FETCH during cycle N+1 -> first dump_valid in cycle N+2; with dump_ready held 1, full dump = 48 cycles then DONE.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE; start in DONE or any busy state SHALL be ignored without error.
REQ-026 Pair counter SHALL not wrap; pair=15 handshake in SEND_B is the only exit to DONE.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE from any state, including mid-dump, aborting without done.
REQ-028 Reset values: dump_valid 0, dump_address 0, dump_data 0, busy 0, done 0, error 0, all read addresses 0, pair 0, buffers 0.
REQ-029 reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro REGDUMP_SKIP_ZERO_EN defined: pair 0 SHALL go FETCH -> SEND_B directly, omitting register 0 beat (31 beats, 1..31, 47 cycles at full rate).
REQ-031 Macro REGDUMP_SKIP_ZERO_EN undefined: all 32 beats SHALL be emitted, including register 0.

Verification
REQ-032 cores=1, regs preloaded r[k]=k*0x11, start core 0, dump_ready=1 -> 32 beats addr 0..31, data k*0x11, done pulse 48 cycles after FETCH start.
REQ-033 cores=4, r2[15]=0x10101, start core_select=2 -> beat addr 15 data 0x10101; lanes 0,1,3 read addresses remain 0 throughout.
REQ-034 dump_ready toggled 1-of-3 cycles -> address/data stable while stalled, 32 beats, no duplicates, no losses.
REQ-035 cores=4, start core_select=5 -> error pulses one cycle, busy stays 0, no dump_valid.
REQ-036 reset asserted during beat addr 9 -> next cycle dump_valid 0, busy 0, done never pulses; new start dumps from addr 0.
REQ-037 REGDUMP_SKIP_ZERO_EN defined -> first beat addr 1, 31 beats total, done pulse as normal.
